// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared types and helpers for the pipeline performance monitor.
package perf_mon_pkg;

  // Run control: counters advance only in RUN_RUN; RUN_HALT is left only by clear.
  typedef enum logic [1:0] {
    RUN_IDLE = 2'd0,
    RUN_RUN  = 2'd1,
    RUN_HALT = 2'd2
  } run_state_e;

  // Snapshot streamer.
  typedef enum logic {
    D_IDLE = 1'b0,
    D_SEND = 1'b1
  } dump_state_e;

  // Dump word 0 is always the cycle counter; word k is event k-1.
  localparam int IDX_CYCLE = 0;

  // Width of the dump word index for num_evt event channels (+1 cycle word).
  function automatic int idx_width(input int num_evt);
    return (num_evt < 1) ? 1 : $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/pipeline_perf_monitor_if.sv
// Snapshot dump stream (valid/ready) between the monitor and its sink.
interface pipeline_perf_monitor_if
  import perf_mon_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 4,
  parameter int IDX_W   = idx_width(NUM_EVT)
);
  logic             dump_valid_o;
  logic [IDX_W-1:0] dump_idx_o;
  logic [CNT_W-1:0] dump_data_o;
  logic             dump_last_o;
  logic             dump_ready_i;

  modport master (
    output dump_valid_o, dump_idx_o, dump_data_o, dump_last_o,
    input  dump_ready_i
  );

  modport slave (
    input  dump_valid_o, dump_idx_o, dump_data_o, dump_last_o,
    output dump_ready_i
  );
endinterface

// File: rtl/pipeline_perf_monitor_sat_counter.sv
// Saturating event counter with sticky overflow flag and synchronous clear.
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] value_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;

  // Next value: clear wins; an increment at all-ones holds the value and flags overflow.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i && inc_i) begin
      if (&value_q) ovf_d = 1'b1;
      else          value_d = value_q + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle/event performance monitor: run/halt control, saturating counters and a
// frozen-snapshot dump over a valid/ready stream.
module pipeline_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 4,
  parameter int IDX_W   = idx_width(NUM_EVT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [NUM_EVT-1:0]     evt_i,
  input  logic [CNT_W-1:0]       stop_cycle_i,
  input  logic                   snap_req_i,
  pipeline_perf_monitor_if.master dump,
  output logic                   halt_o,
  output logic [NUM_EVT:0]       ovf_o,
  output logic [CNT_W-1:0]       cycle_o
);
  localparam int              NUM_CNT  = NUM_EVT + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_EVT);

  run_state_e                  run_q, run_d;
  dump_state_e                 dump_q, dump_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_EVT:0][CNT_W-1:0] shadow_q, shadow_d;
  logic [NUM_EVT:0][CNT_W-1:0] cnt_val;
  logic [NUM_EVT:0]            cnt_inc;
  logic                        count_en;
  logic                        hit_stop;

  // Counter 0 counts every enabled cycle; counter k counts raw evt_i[k-1].
  assign cnt_inc = {evt_i, 1'b1};

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (cnt_inc[g]),
      .clr_i   (clear_i),
      .en_i    (count_en),
      .value_o (cnt_val[g]),
      .ovf_o   (ovf_o[g])
    );
  end

  // Limit reached when the value the cycle counter is about to take equals a
  // non-zero stop; a saturated counter wraps here to 0 and so never matches.
  assign hit_stop = (stop_cycle_i != '0) &&
                    ((cnt_val[IDX_CYCLE] + CNT_W'(1)) == stop_cycle_i);

  // Run FSM: next state and counter enable; clear overrides everything.
  always_comb begin
    run_d    = run_q;
    count_en = 1'b0;
    if (clear_i) begin
      run_d = RUN_IDLE;
    end else begin
      case (run_q)
        RUN_IDLE: if (start_i) run_d = RUN_RUN;
        RUN_RUN: begin
          if (!start_i) begin
            run_d = RUN_IDLE;
          end else begin
            count_en = 1'b1;
            if (hit_stop) run_d = RUN_HALT;
          end
        end
        RUN_HALT: run_d = RUN_HALT;
        default:  run_d = RUN_IDLE;
      endcase
    end
  end

  // Dump FSM: capture pre-increment live values on request, then walk the words.
  always_comb begin
    dump_d   = dump_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (dump_q)
      D_IDLE: begin
        if (snap_req_i) begin
          shadow_d = cnt_val;
          idx_d    = '0;
          dump_d   = D_SEND;
        end
      end
      D_SEND: begin
        if (dump.dump_ready_i) begin
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            dump_d = D_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: dump_d = D_IDLE;
    endcase
  end

  // State registers; reset aborts any dump immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q    <= RUN_IDLE;
      dump_q   <= D_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      run_q    <= run_d;
      dump_q   <= dump_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs are pure functions of registered state, so they hold while stalled.
  assign halt_o            = (run_q == RUN_HALT);
  assign cycle_o           = cnt_val[IDX_CYCLE];
  assign dump.dump_valid_o = (dump_q == D_SEND);
  assign dump.dump_idx_o   = idx_q;
  assign dump.dump_last_o  = (dump_q == D_SEND) && (idx_q == IDX_LAST);
  assign dump.dump_data_o  = (dump_q == D_SEND) ? shadow_q[idx_q] : '0;
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor: a 32-bit instance plus a 4-bit instance
// (for saturation), both driven from the same stimulus and compared against an
// unbounded-count reference model.
module tb_pipeline_perf_monitor;
  localparam int CNT_W   = 32;
  localparam int NUM_EVT = 4;
  localparam int NC      = NUM_EVT + 1;
  localparam int IDX_W   = $clog2(NUM_EVT + 1);
  localparam int W4      = 4;

  logic               clk_i = 1'b0;
  logic               rst_i, start_i, clear_i, snap_req_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [CNT_W-1:0]   stop_cycle_i;
  logic [W4-1:0]      stop4;
  logic               halt_o, halt4;
  logic [NUM_EVT:0]   ovf_o, ovf4;
  logic [CNT_W-1:0]   cycle_o;
  logic [W4-1:0]      cyc4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pipeline_perf_monitor_if #(.CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dif ();
  pipeline_perf_monitor_if #(.CNT_W(W4),    .NUM_EVT(NUM_EVT)) dif4 ();
  assign dif4.dump_ready_i = dif.dump_ready_i;
  assign stop4 = '0;

  pipeline_perf_monitor #(.CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .evt_i(evt_i),
    .stop_cycle_i(stop_cycle_i), .snap_req_i(snap_req_i), .dump(dif),
    .halt_o(halt_o), .ovf_o(ovf_o), .cycle_o(cycle_o));

  pipeline_perf_monitor #(.CNT_W(W4), .NUM_EVT(NUM_EVT)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .evt_i(evt_i),
    .stop_cycle_i(stop4), .snap_req_i(snap_req_i), .dump(dif4),
    .halt_o(halt4), .ovf_o(ovf4), .cycle_o(cyc4));

  // ---------------- reference model ----------------
  // Unbounded counts; widths applied only when comparing.
  longint m_cnt[NC];
  bit     m_halt, m_start_prev, m_clear_prev;
  longint e32[NC], e4[NC];

  function automatic longint maxv(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sat(input longint n, input int w);
    return (n > maxv(w)) ? maxv(w) : n;
  endfunction

  function automatic logic [NUM_EVT:0] exp_ovf(input int w);
    logic [NUM_EVT:0] r;
    for (int k = 0; k < NC; k++) r[k] = (m_cnt[k] > maxv(w));
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_cnt[k] = 0;
    m_halt = 0; m_start_prev = 0; m_clear_prev = 0;
  endtask

  // A cycle counts when start has been high for this and the previous cycle,
  // no clear in either, and the limit has not been hit.
  task automatic model_edge();
    bit counts;
    counts = start_i && m_start_prev && !m_clear_prev && !m_halt && !clear_i;
    if (rst_i) begin
      model_reset();
    end else begin
      if (clear_i) begin
        for (int k = 0; k < NC; k++) m_cnt[k] = 0;
        m_halt = 0;
      end else if (counts) begin
        m_cnt[0]++;
        for (int k = 0; k < NUM_EVT; k++) if (evt_i[k]) m_cnt[k+1]++;
        if (stop_cycle_i != 0 && sat(m_cnt[0], CNT_W) == longint'(stop_cycle_i)) m_halt = 1;
      end
      m_start_prev = start_i;
      m_clear_prev = clear_i;
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  // Expected snapshot is the model state before the snap edge.
  task automatic do_snap();
    for (int k = 0; k < NC; k++) begin
      e32[k] = sat(m_cnt[k], CNT_W);
      e4[k]  = sat(m_cnt[k], W4);
    end
    snap_req_i = 1'b1;
    cyc();
    snap_req_i = 1'b0;
  endtask

  // ---------------- dump collector ----------------
  longint c_w32[NC], c_w4[NC];
  int     c_idx[NC];
  bit     c_last[NC];
  int     c_nx, c_unstable, c_steps;
  bit     c_tout;

  // mode 0: ready always, 1: ready toggles, 2: random ready.
  task automatic collect(input int mode, input bit rnd_evt, input int snap_at, input int clear_at);
    bit r, done, prev_stall;
    logic [IDX_W-1:0] p_idx;
    logic [CNT_W-1:0] p_data;
    c_nx = 0; c_unstable = 0; c_steps = 0; c_tout = 0;
    done = 0; prev_stall = 0; p_idx = '0; p_data = '0;
    while (!done) begin
      if (c_steps >= 64) begin c_tout = 1; break; end
      case (mode)
        0:       r = 1'b1;
        1:       r = (c_steps % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dif.dump_ready_i = r;
      if (rnd_evt) evt_i = NUM_EVT'($urandom);
      snap_req_i = (c_steps == snap_at);
      clear_i    = (c_steps == clear_at);
      if (prev_stall && (dif.dump_valid_o !== 1'b1 || dif.dump_idx_o !== p_idx ||
                         dif.dump_data_o !== p_data)) c_unstable++;
      if (dif.dump_valid_o === 1'b1 && r) begin
        if (c_nx < NC) begin
          c_w32[c_nx]  = longint'(dif.dump_data_o);
          c_w4[c_nx]   = longint'(dif4.dump_data_o);
          c_idx[c_nx]  = int'(dif.dump_idx_o);
          c_last[c_nx] = dif.dump_last_o;
        end
        c_nx++;
        if (dif.dump_last_o === 1'b1) done = 1;
      end
      prev_stall = (dif.dump_valid_o === 1'b1) && !r;
      p_idx  = dif.dump_idx_o;
      p_data = dif.dump_data_o;
      cyc();
      c_steps++;
    end
    snap_req_i = 1'b0;
    clear_i    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; start_i = 0; clear_i = 0; snap_req_i = 0; evt_i = '0;
    stop_cycle_i = '0; dif.dump_ready_i = 1'b0;
    model_reset();
    cyc(); cyc();
    n_vec++; if (dif.dump_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", dif.dump_valid_o); end
    n_vec++; if (dif.dump_idx_o !== '0) begin n_err++; $display("FAIL rst_idx got %0d want 0", dif.dump_idx_o); end
    n_vec++; if (dif.dump_data_o !== '0) begin n_err++; $display("FAIL rst_data got %0d want 0", dif.dump_data_o); end
    n_vec++; if (dif.dump_last_o !== 1'b0) begin n_err++; $display("FAIL rst_last got %0b want 0", dif.dump_last_o); end
    n_vec++; if (halt_o !== 1'b0) begin n_err++; $display("FAIL rst_halt got %0b want 0", halt_o); end
    n_vec++; if (ovf_o !== '0) begin n_err++; $display("FAIL rst_ovf got %b want 0", ovf_o); end
    n_vec++; if (cycle_o !== '0) begin n_err++; $display("FAIL rst_cycle got %0d want 0", cycle_o); end
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_halt();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    stop_cycle_i = 32'd10; start_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      evt_i = '0;
      evt_i[0] = (m_cnt[0] >= 2 && m_cnt[0] < 5);  // counted cycles 3..5
      cyc();
      n_vec++; if (cycle_o !== CNT_W'(sat(m_cnt[0], CNT_W)))
        begin n_err++; $display("FAIL halt_cycle[%0d] got %0d want %0d", i, cycle_o, sat(m_cnt[0], CNT_W)); end
      n_vec++; if (halt_o !== m_halt)
        begin n_err++; $display("FAIL halt_flag[%0d] got %0b want %0b", i, halt_o, m_halt); end
    end
    evt_i = '0;
    n_vec++; if (halt_o !== 1'b1 || cycle_o !== 32'd10)
      begin n_err++; $display("FAIL halt_final got halt=%0b cycle=%0d want 1/10", halt_o, cycle_o); end
    do_snap();
    collect(0, 0, -1, -1);
    n_vec++; if (c_tout || c_nx != NC || c_w32[0] != 10 || c_w32[1] != 3)
      begin n_err++; $display("FAIL halt_dump got n=%0d cyc=%0d cnt0=%0d want %0d/10/3", c_nx, c_w32[0], c_w32[1], NC); end
  endtask

  task automatic test_dump();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    stop_cycle_i = '0; start_i = 1'b1;
    for (int i = 0; i < 40 && m_cnt[0] != 20; i++) begin
      evt_i = NUM_EVT'($urandom);
      cyc();
    end
    do_snap();
    n_vec++; if (dif.dump_valid_o !== 1'b1 || dif.dump_idx_o !== '0)
      begin n_err++; $display("FAIL dump_latency got valid=%0b idx=%0d want 1/0", dif.dump_valid_o, dif.dump_idx_o); end
    collect(0, 1, -1, -1);
    n_vec++; if (c_tout || c_nx != NC || c_steps != NC)
      begin n_err++; $display("FAIL dump_len got n=%0d steps=%0d want %0d", c_nx, c_steps, NC); end
    n_vec++; if (c_w32[0] != 20)
      begin n_err++; $display("FAIL dump_cycle_word got %0d want 20", c_w32[0]); end
    for (int k = 0; k < NC; k++) begin
      n_vec++; if (c_w32[k] != e32[k] || c_idx[k] != k || c_last[k] != (k == NC - 1))
        begin n_err++; $display("FAIL dump_word[%0d] got d=%0d i=%0d l=%0b want d=%0d i=%0d", k, c_w32[k], c_idx[k], c_last[k], e32[k], k); end
    end
    n_vec++; if (dif.dump_valid_o !== 1'b0)
      begin n_err++; $display("FAIL dump_end_valid got %0b want 0", dif.dump_valid_o); end
  endtask

  // Ready toggles; a second snap and a clear arrive mid-dump and must not disturb it.
  task automatic test_backpressure();
    do_snap();
    collect(1, 1, 3, 5);
    n_vec++; if (c_tout || c_nx != NC || c_steps <= NC)
      begin n_err++; $display("FAIL bp_len got n=%0d steps=%0d want %0d/>%0d", c_nx, c_steps, NC, NC); end
    n_vec++; if (c_unstable != 0)
      begin n_err++; $display("FAIL bp_stable got %0d changes want 0", c_unstable); end
    for (int k = 0; k < NC; k++) begin
      n_vec++; if (c_w32[k] != e32[k] || c_idx[k] != k)
        begin n_err++; $display("FAIL bp_word[%0d] got d=%0d i=%0d want d=%0d i=%0d", k, c_w32[k], c_idx[k], e32[k], k); end
    end
    n_vec++; if (cycle_o !== CNT_W'(sat(m_cnt[0], CNT_W)))
      begin n_err++; $display("FAIL bp_live_cycle got %0d want %0d", cycle_o, sat(m_cnt[0], CNT_W)); end
  endtask

  task automatic test_saturation();
    start_i = 1'b0; clear_i = 1'b1; cyc(); clear_i = 1'b0;
    n_vec++; if (ovf4 !== '0) begin n_err++; $display("FAIL sat_pre_ovf got %b want 0", ovf4); end
    start_i = 1'b1; evt_i = 4'b0010;
    for (int i = 0; i < 40 && m_cnt[2] < 20; i++) cyc();
    n_vec++; if (ovf4 !== exp_ovf(W4) || ovf4[2] !== 1'b1 || ovf4[1] !== 1'b0)
      begin n_err++; $display("FAIL sat_ovf4 got %b want %b", ovf4, exp_ovf(W4)); end
    n_vec++; if (ovf_o !== '0 || halt4 !== 1'b0)
      begin n_err++; $display("FAIL sat_ovf32 got ovf=%b halt4=%0b want 0/0", ovf_o, halt4); end
    n_vec++; if (cyc4 !== 4'd15) begin n_err++; $display("FAIL sat_cyc4 got %0d want 15", cyc4); end
    start_i = 1'b0; evt_i = '0;
    do_snap();
    collect(0, 0, -1, -1);
    n_vec++; if (c_tout || c_nx != NC || c_w4[2] != 15 || c_w4[1] != 0)
      begin n_err++; $display("FAIL sat_dump got cnt1=%0d cnt0=%0d want 15/0", c_w4[2], c_w4[1]); end
    for (int k = 0; k < NC; k++) begin
      n_vec++; if (c_w4[k] != e4[k])
        begin n_err++; $display("FAIL sat_word[%0d] got %0d want %0d", k, c_w4[k], e4[k]); end
    end
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    n_vec++; if (ovf4 !== '0 || cyc4 !== '0)
      begin n_err++; $display("FAIL sat_clear got ovf=%b cyc=%0d want 0/0", ovf4, cyc4); end
    do_snap();
    collect(0, 0, -1, -1);
    n_vec++; if (c_tout || c_w4[2] != 0 || c_w4[0] != 0)
      begin n_err++; $display("FAIL sat_clear_dump got cnt1=%0d cyc=%0d want 0/0", c_w4[2], c_w4[0]); end
  endtask

  task automatic test_pause();
    longint hold;
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) begin evt_i = NUM_EVT'($urandom); cyc(); end
    hold = m_cnt[0];
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++; if (cycle_o !== CNT_W'(hold))
        begin n_err++; $display("FAIL pause_hold[%0d] got %0d want %0d", i, cycle_o, hold); end
    end
    start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_vec++; if (cycle_o !== CNT_W'(sat(m_cnt[0], CNT_W)))
        begin n_err++; $display("FAIL pause_resume[%0d] got %0d want %0d", i, cycle_o, sat(m_cnt[0], CNT_W)); end
    end
    n_vec++; if (cycle_o !== CNT_W'(hold + 3))
      begin n_err++; $display("FAIL pause_total got %0d want %0d", cycle_o, hold + 3); end
  endtask

  task automatic test_random();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    stop_cycle_i = 32'd90;
    for (int i = 0; i < 300; i++) begin
      start_i = ($urandom_range(0, 9) != 0);
      evt_i   = NUM_EVT'($urandom);
      clear_i = ($urandom_range(0, 49) == 0);
      cyc();
      clear_i = 1'b0;
      n_vec++; if (cycle_o !== CNT_W'(sat(m_cnt[0], CNT_W)) || halt_o !== m_halt || ovf_o !== exp_ovf(CNT_W))
        begin n_err++; $display("FAIL rnd_live[%0d] got c=%0d h=%0b o=%b want c=%0d h=%0b", i, cycle_o, halt_o, ovf_o, sat(m_cnt[0], CNT_W), m_halt); end
      if (i % 75 == 74) begin
        do_snap();
        collect(2, 1, -1, -1);
        for (int k = 0; k < NC; k++) begin
          n_vec++; if (c_tout || c_w32[k] != e32[k] || c_idx[k] != k)
            begin n_err++; $display("FAIL rnd_word[%0d.%0d] got %0d want %0d", i, k, c_w32[k], e32[k]); end
        end
      end
    end
  endtask

  task automatic test_rst_mid_dump();
    int guard;
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    stop_cycle_i = 32'd7; start_i = 1'b1;
    for (int i = 0; i < 20 && !m_halt; i++) begin evt_i = NUM_EVT'($urandom); cyc(); end
    do_snap();
    dif.dump_ready_i = 1'b1;
    guard = 0;
    while (dif.dump_idx_o !== IDX_W'(2) && guard < 10) begin cyc(); guard++; end
    n_vec++; if (guard >= 10 || halt_o !== 1'b1)
      begin n_err++; $display("FAIL rst_dump_setup got idx=%0d halt=%0b want 2/1", dif.dump_idx_o, halt_o); end
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    n_vec++; if (dif.dump_valid_o !== 1'b0 || dif.dump_idx_o !== '0 || dif.dump_data_o !== '0)
      begin n_err++; $display("FAIL rst_dump_abort got v=%0b i=%0d want 0/0", dif.dump_valid_o, dif.dump_idx_o); end
    n_vec++; if (cycle_o !== '0 || halt_o !== 1'b0 || ovf_o !== '0 || cyc4 !== '0)
      begin n_err++; $display("FAIL rst_dump_state got c=%0d h=%0b want 0/0", cycle_o, halt_o); end
    cyc();
    rst_i = 1'b0;
    cyc();
    n_vec++; if (dif.dump_valid_o !== 1'b0)
      begin n_err++; $display("FAIL rst_dump_after got %0b want 0", dif.dump_valid_o); end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_dump();
    test_backpressure();
    test_saturation();
    test_pause();
    test_random();
    test_rst_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
